// File: rtl/uart_fifo_port.sv
// FIFO-buffered UART transceiver with valid/ready streams and framing/overrun detection.
// Define UART_PARITY_EN to insert and check one parity bit per frame.
module uart_fifo_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
endmodule

module uart_fifo_port #(
    parameter int CLK_HZ     = 21477000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_frame_err,
    output logic                          rx_overrun,
    output logic                          rx_parity_err,
    input  logic                          uart_port_DI,
    output logic                          uart_port_DO
);
    localparam int     NCLKS    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int     LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int     CW       = $clog2(NCLKS);
    localparam longint BAUD_DIF = longint'(NCLKS) * longint'(BAUD) - longint'(CLK_HZ);
    localparam longint BAUD_ABS = (BAUD_DIF < 0) ? -BAUD_DIF : BAUD_DIF;
    localparam logic [CW-1:0] CNT_BIT  = CW'(NCLKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(NCLKS / 2 - 1);

    if (NCLKS < 16 || DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1) || BAUD_ABS * 50 >= longint'(CLK_HZ)) begin : g_param_check
        $error("uart_fifo_port: illegal parameter set");
    end

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA,
`ifdef UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP, R_BREAK
    } rx_state_t;

    logic                 tx_push, tx_pop, tx_empty, tx_line;
    logic [DATA_BITS-1:0] tx_head;
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;

    assign tx_ready = (tx_level != LW'(FIFO_DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign tx_empty = (tx_level == '0);

    uart_fifo_port_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(tx_data),
        .pop(tx_pop), .rdata(tx_head), .level(tx_level)
    );

`ifdef UART_PARITY_EN
    logic tx_par, tx_par_n;
`endif

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_cnt == '0) ? CNT_BIT : tx_cnt - CW'(1);
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            T_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_head;
                    tx_cnt_n   = CNT_BIT;
                    tx_state_n = T_START;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_head ^ 1'(PARITY_ODD);
`endif
                end
            end
            T_START: begin
                tx_line = 1'b0;
                if (tx_cnt == '0) begin
                    tx_bit_n   = '0;
                    tx_state_n = T_DATA;
                end
            end
            T_DATA: begin
                tx_line = tx_sh[0];
                if (tx_cnt == '0) begin
                    tx_sh_n  = tx_sh >> 1;
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'(DATA_BITS - 1)) begin
                        tx_bit_n   = '0;
`ifdef UART_PARITY_EN
                        tx_state_n = T_PARITY;
`else
                        tx_state_n = T_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PARITY: begin
                tx_line = tx_par;
                if (tx_cnt == '0) tx_state_n = T_STOP;
            end
`endif
            T_STOP: begin
                if (tx_cnt == '0) begin
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'(STOP_BITS - 1)) begin
                        tx_bit_n   = '0;
                        tx_state_n = T_IDLE;
                        // Chain straight into the next start bit so frames stay gapless.
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_sh_n    = tx_head;
                            tx_state_n = T_START;
`ifdef UART_PARITY_EN
                            tx_par_n   = ^tx_head ^ 1'(PARITY_ODD);
`endif
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= T_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_sh        <= '0;
            uart_port_DO <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par       <= 1'b0;
`endif
        end else begin
            tx_state     <= tx_state_n;
            tx_cnt       <= tx_cnt_n;
            tx_bit       <= tx_bit_n;
            tx_sh        <= tx_sh_n;
            uart_port_DO <= tx_line;
`ifdef UART_PARITY_EN
            tx_par       <= tx_par_n;
`endif
        end
    end

    logic                 rx_s1, rx_in;
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_push_req, rx_pop, rx_full, rx_fifo_push;
    logic                 frame_err_n, parity_err_n;

    assign rx_valid     = (rx_level != '0);
    assign rx_pop       = rx_valid && rx_ready;
    assign rx_full      = (rx_level == LW'(FIFO_DEPTH));
    assign rx_fifo_push = rx_push_req && (!rx_full || rx_pop);

    uart_fifo_port_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_fifo_push), .wdata(rx_sh),
        .pop(rx_pop), .rdata(rx_data), .level(rx_level)
    );

`ifdef UART_PARITY_EN
    logic rx_perr, rx_perr_n;
`endif

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = (rx_cnt == '0) ? CNT_BIT : rx_cnt - CW'(1);
        rx_bit_n     = rx_bit;
        rx_sh_n      = rx_sh;
        rx_push_req  = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_n    = rx_perr;
`endif
        case (rx_state)
            R_IDLE: begin
                if (!rx_in) begin
                    rx_cnt_n   = CNT_HALF;
                    rx_state_n = R_START;
                end
            end
            R_START: begin
                if (rx_cnt == '0) begin
                    rx_bit_n   = '0;
                    rx_state_n = rx_in ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_n  = {rx_in, rx_sh[DATA_BITS-1:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_n = R_PARITY;
`else
                        rx_state_n = R_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
                if (rx_cnt == '0) begin
                    rx_perr_n  = rx_in ^ (^rx_sh) ^ 1'(PARITY_ODD);
                    rx_state_n = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (rx_cnt == '0) begin
                    if (rx_in) begin
                        rx_state_n = R_IDLE;
`ifdef UART_PARITY_EN
                        rx_push_req  = !rx_perr;
                        parity_err_n = rx_perr;
`else
                        rx_push_req  = 1'b1;
`endif
                    end else begin
                        frame_err_n = 1'b1;
                        rx_state_n  = R_BREAK;
                    end
                end
            end
            R_BREAK: begin
                if (rx_in) rx_state_n = R_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1         <= 1'b1;
            rx_in         <= 1'b1;
            rx_state      <= R_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_sh         <= '0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_parity_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr       <= 1'b0;
`endif
        end else begin
            rx_s1         <= uart_port_DI;
            rx_in         <= rx_s1;
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_bit        <= rx_bit_n;
            rx_sh         <= rx_sh_n;
            rx_frame_err  <= frame_err_n;
            rx_overrun    <= rx_push_req && rx_full && !rx_pop;
`ifdef UART_PARITY_EN
            rx_parity_err <= parity_err_n;
            rx_perr       <= rx_perr_n;
`else
            rx_parity_err <= parity_err_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port: TX waveform, loopback, RX error vectors, overrun, async reset.
module tb_uart_fifo_port;
    localparam int NCLKS      = 186;
    localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FRAME = FBITS * NCLKS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_level, rx_level;
    logic       rx_frame_err, rx_overrun, rx_parity_err;
    logic       line_di, line_do;
    logic       di_drv = 1'b1;
    logic       loop = 1'b0;

    int n_cmp = 0, n_fail = 0;
    int n_fe = 0, n_ov = 0, n_pe = 0;

    assign line_di = loop ? line_do : di_drv;

    always #5 clk = ~clk;

    uart_fifo_port #(
        .CLK_HZ(21477000), .BAUD(115200), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err),
        .uart_port_DI(line_di), .uart_port_DO(line_do)
    );

    always @(negedge clk) begin
        if (rx_frame_err  === 1'b1) n_fe <= n_fe + 1;
        if (rx_overrun    === 1'b1) n_ov <= n_ov + 1;
        if (rx_parity_err === 1'b1) n_pe <= n_pe + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic       exp_push;
        int         exp_fe;
    } rx_vec_t;
    rx_vec_t vecs [5];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        int w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin
            tick(1);
            w++;
        end
        if (tx_ready !== 1'b1) chk("tx_ready_wait", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge N of a push into an idle transmitter.
    task automatic check_tx_frame(input logic [7:0] b);
        logic [11:0] e;
        e    = '1;
        e[0] = 1'b0;
        for (int i = 0; i < 8; i++) e[i+1] = b[i];
`ifdef UART_PARITY_EN
        e[9] = ^b ^ 1'(PARITY_ODD);
`endif
        chk("tx_latency_n", line_do, 1);
        tick(1);
        chk("tx_latency_n1", line_do, 1);
        tick(1);
        for (int j = 0; j < FBITS; j++) begin
            chk($sformatf("tx_0x%0h_bit%0d_first", b, j), line_do, e[j]);
            tick(NCLKS - 1);
            chk($sformatf("tx_0x%0h_bit%0d_last", b, j), line_do, e[j]);
            tick(1);
        end
        chk("tx_idle_after", line_do, 1);
        chk("tx_level_empty", tx_level, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        di_drv = 1'b0;
        tick(NCLKS);
        for (int i = 0; i < 8; i++) begin
            di_drv = b[i];
            tick(NCLKS);
        end
`ifdef UART_PARITY_EN
        di_drv = ^b ^ 1'(PARITY_ODD) ^ par_flip;
        tick(NCLKS);
`else
        if (par_flip) tick(0);
`endif
        di_drv = stop;
        tick(NCLKS);
    endtask

    initial begin
        int fe0, ov0, pe0, w;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h96, 1'b1, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 0};

        tick(3);
        chk("rst_do", line_do, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_pulses", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
        rst_n = 1'b1;
        tick(2);

        push_tx(8'hA5);
        check_tx_frame(8'hA5);

        // Loopback: three back-to-back bytes, gapless on the line.
        loop = 1'b1;
        fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        tick(2);
        tx_valid = 1'b1;
        tx_data = 8'h00; @(posedge clk); #1;
        tx_data = 8'hFF; @(posedge clk); #1;
        tx_data = 8'h55; @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("lb_tx_level_pushpop", tx_level, 2);
        chk("lb_start1", line_do, 0);
        tick(FRAME - 1);
        chk("lb_stop1_last", line_do, 1);
        tick(1);
        chk("lb_start2_nogap", line_do, 0);
        tick(FRAME - 1);
        chk("lb_stop2_last", line_do, 1);
        tick(1);
        chk("lb_start3_nogap", line_do, 0);
        w = 0;
        while (rx_level != 5'd3 && w < 3000) begin
            tick(1);
            w++;
        end
        chk("lb_rx_level", rx_level, 3);
        chk("lb_rx0", rx_data, 8'h00); pop_rx();
        chk("lb_rx1", rx_data, 8'hFF); pop_rx();
        chk("lb_rx2", rx_data, 8'h55); pop_rx();
        chk("lb_rx_empty", rx_valid, 0);
        chk("lb_no_errs", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);
        tick(200);
        loop = 1'b0;
        tick(50);

        for (int i = 0; i < 5; i++) begin
            fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
            if (vecs[i].glitch) begin
                di_drv = 1'b0;
                tick(50);
                di_drv = 1'b1;
                tick(400);
            end else begin
                send_frame(vecs[i].data, vecs[i].stop, 1'b0);
                if (!vecs[i].stop) begin
                    tick(400);
                    di_drv = 1'b1;
                end
            end
            tick(300);
            chk($sformatf("vec%0d_rx_level", i), rx_level, {4'd0, vecs[i].exp_push});
            chk($sformatf("vec%0d_frame_err", i), n_fe - fe0, vecs[i].exp_fe);
            chk($sformatf("vec%0d_overrun", i), n_ov - ov0, 0);
            if (vecs[i].exp_push) begin
                chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].data);
                pop_rx();
            end
        end

        // Overrun: 17 frames into a 16-deep FIFO with no consumer.
        ov0 = n_ov; fe0 = n_fe;
        for (int i = 0; i < 17; i++) send_frame(8'(i + 1), 1'b1, 1'b0);
        tick(20);
        chk("ovr_rx_level", rx_level, 16);
        chk("ovr_pulses", n_ov - ov0, 1);
        chk("ovr_no_fe", n_fe - fe0, 0);
        chk("ovr_head", rx_data, 8'h01);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr_drain%0d", i), rx_data, 32'(i + 1));
            pop_rx();
        end
        chk("ovr_empty", rx_level, 0);

`ifdef UART_PARITY_EN
        pe0 = n_pe;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(20);
        chk("par_bad_pulse", n_pe - pe0, 1);
        chk("par_bad_dropped", rx_level, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        tick(20);
        chk("par_good_level", rx_level, 1);
        chk("par_good_data", rx_data, 8'h07);
        pop_rx();
        chk("par_total", n_pe, 1);
`else
        chk("par_never", n_pe, 0);
`endif

        // Reset during data bit 4 of a frame with one more byte queued.
        push_tx(8'hC3);
        push_tx(8'h5A);
        tick(1024);
        chk("rst_mid_do_before", line_do, 0);
        chk("rst_mid_level_before", tx_level, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_do", line_do, 1);
        chk("rst_mid_tx_level", tx_level, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        push_tx(8'h81);
        check_tx_frame(8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #10000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
